// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the fetch PC, issues word reads,
// and buffers in-order responses with their PCs for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic [CW:0]   inflight;
    logic          fire;
    logic          resp_live;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;
    logic          unused_bits;

    // Queue slots already spoken for: buffered words plus reads in flight.
    assign inflight  = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = !rst && !redirect_valid && (inflight < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    // A response with nothing outstanding is spurious and ignored.
    assign resp_live = imem_rvalid && (outstanding != '0);
    assign drop      = (discard != '0);
    assign push      = resp_live && !drop && !redirect_valid;
    assign pop       = instr_valid && instr_ready && !redirect_valid;

    assign target_pc   = {redirect_pc[31:2], 2'b00};
    assign unused_bits = ^{redirect_pc[1:0]};

    assign instr_valid = (count != '0);
    assign instr_o     = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    // Fetch PC: redirect target, else advance on each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
        end else if (redirect_valid) begin
            fetch_pc <= target_pc;
        end else if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // PC tagged onto the next kept response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_pc <= {RESET_PC[31:2], 2'b00};
        end else if (redirect_valid) begin
            resp_pc <= target_pc;
        end else if (push) begin
            resp_pc <= resp_pc + 32'd4;
        end
    end

    // In-flight read tracking; a redirect marks every surviving read stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(resp_live);
            if (redirect_valid) begin
                discard <= outstanding - CW'(resp_live);
            end else if (resp_live && drop) begin
                discard <= discard - CW'(1'b1);
            end
        end
    end

    // Queue occupancy and pointers; redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1'b1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1'b1);
            end
        end
    end

    // Queue storage: word and its PC written together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    spurious_rvalid: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, corner sequences with a
// memory model, and a randomized run checked against an expected-PC stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc;

    logic        rst2 = 1'b1;
    logic        gnt2 = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_o(instr_o), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(gnt2), .imem_rvalid(1'b0),
        .imem_rdata(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(valid2), .instr_ready(1'b0),
        .instr_o(instr2), .instr_pc(pc2)
    );

    int n_run = 0;
    int n_fail = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    bit          lat_rand = 0;
    bit          rand_gnt = 0;
    bit          prev_redir = 0;
    logic [31:0] exp_pc = '0;
    int          n_gnt = 0;
    int          n_pop = 0;
    logic [31:0] first_pc = '0;

    // One cycle: memory model drives responses, bench samples and scores.
    task automatic step();
        int d;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = f(mq[0].addr);
        end
        if (rand_gnt) imem_gnt = ($urandom_range(3) != 0);
        #1;
        if (rst) begin
            mq.delete();
            last_due = 0;
            exp_pc = '0;
        end else begin
            if (prev_redir) chk("post_redirect_valid", 32'(instr_valid), 32'd0);
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_gnt) begin
                d = cyc + (lat_rand ? $urandom_range(4, 1) : lat);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{imem_addr, d});
                n_gnt++;
            end
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (instr_valid && instr_ready) begin
                if (n_pop == 0) first_pc = instr_pc;
                chk("pop_pc", instr_pc, exp_pc);
                chk("pop_instr", instr_o, f(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
        end
        prev_redir = redirect_valid && !rst;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h0,       0, 32'h0,   1, 0, 32'h0,   0, 32'h0};
        tbl[1]  = '{1, 1, 0, 32'h0,       0, 32'h0,   1, 0, 32'h0,   0, 32'h0};
        tbl[2]  = '{0, 1, 0, 32'h0,       0, 32'h0,   1, 1, 32'h0,   0, 32'h0};
        tbl[3]  = '{0, 1, 1, f(32'h0),    0, 32'h0,   1, 1, 32'h4,   0, 32'h0};
        tbl[4]  = '{0, 1, 1, f(32'h4),    0, 32'h0,   1, 1, 32'h8,   1, 32'h0};
        tbl[5]  = '{0, 1, 1, f(32'h8),    0, 32'h0,   1, 1, 32'hC,   1, 32'h4};
        tbl[6]  = '{0, 1, 1, f(32'hC),    1, 32'h203, 1, 0, 32'h10,  1, 32'h8};
        tbl[7]  = '{0, 1, 0, 32'h0,       0, 32'h0,   1, 1, 32'h200, 0, 32'h0};
        tbl[8]  = '{0, 1, 1, f(32'h200),  0, 32'h0,   1, 1, 32'h204, 0, 32'h0};
        tbl[9]  = '{0, 0, 1, f(32'h204),  0, 32'h0,   0, 1, 32'h208, 1, 32'h200};
        tbl[10] = '{0, 0, 0, 32'h0,       0, 32'h0,   0, 1, 32'h208, 1, 32'h200};
        tbl[11] = '{0, 0, 0, 32'h0,       0, 32'h0,   1, 1, 32'h208, 1, 32'h200};
        tbl[12] = '{0, 0, 0, 32'h0,       0, 32'h0,   1, 1, 32'h208, 1, 32'h204};
        tbl[13] = '{0, 0, 0, 32'h0,       0, 32'h0,   1, 1, 32'h208, 0, 32'h0};

        // Wrapping reset PC on the second instance; first stays in reset.
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        gnt2 = 1'b1;
        #1 chk("wrap_addr0", {addr2[31:1], req2}, 32'hFFFF_FFF9);
        @(negedge clk);
        #1 chk("wrap_addr1", {addr2[31:1], req2}, 32'hFFFF_FFFD);
        @(negedge clk);
        #1 chk("wrap_addr2", {addr2[31:1], req2}, 32'h0000_0001);
        chk("wrap_valid", 32'(valid2), 32'd0);
        rst2 = 1'b1;
        gnt2 = 1'b0;
        @(negedge clk);

        // Directed cycle table: streaming, redirect with rvalid+pop, stall.
        for (int i = 0; i < 14; i++) begin
            rst            = tbl[i].rst;
            imem_gnt       = tbl[i].gnt;
            imem_rvalid    = tbl[i].rv;
            imem_rdata     = tbl[i].rdata;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            instr_ready    = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
            if (tbl[i].valid || tbl[i].rst) begin
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_instr", i), instr_o,
                    tbl[i].valid ? f(tbl[i].pc) : 32'h0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;

        // Backpressure: credit limit caps reads at the queue depth.
        lat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        instr_ready = 1'b0;
        n_gnt = 0;
        n_pop = 0;
        repeat (10) step();
        #1;
        chk("bp_grants", n_gnt, 4);
        chk("bp_req_low", 32'(imem_req), 32'd0);
        chk("bp_head_pc", {instr_pc[31:1], instr_valid}, 32'h1);
        instr_ready = 1'b1;
        repeat (8) step();
        chk("bp_drain_pops", 32'(n_pop >= 5), 32'd1);
        chk("bp_first_pc", first_pc, 32'h0);

        // Redirect with three reads in flight at 3-cycle latency.
        lat = 3;
        do_reset();
        repeat (3) step();
        chk("rd_outstanding", mq.size(), 3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        n_pop = 0;
        repeat (12) step();
        chk("rd_first_pc", first_pc, 32'h100);
        chk("rd_pops", 32'(n_pop > 0), 32'd1);

        // Randomized traffic with redirects and occasional resets.
        lat_rand = 1;
        rand_gnt = 1;
        do_reset();
        n_pop = 0;
        repeat (3000) begin
            rst = ($urandom_range(499) == 0);
            redirect_valid = !rst && ($urandom_range(29) == 0);
            redirect_pc = $urandom;
            instr_ready = ($urandom_range(3) != 0);
            step();
        end
        chk("rand_progress", 32'(n_pop > 100), 32'd1);
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
